// File: rtl/sevenseg_scan_ctrl_if.sv
// Signal bundle between the board-side status sources and the seven-segment scan controller.
// The controller takes the slave view; the requester/board side takes the master view.
interface sevenseg_scan_ctrl_if;
    logic [31:0] i_val0;
    logic [31:0] i_val1;
    logic [31:0] i_val2;
    logic [31:0] i_val3;
    logic [1:0]  i_sel;
    logic        i_auto;
    logic        i_lz_blank;
    logic        i_en;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [1:0]  o_src;
    logic        o_frame;

    modport master (
        output i_val0, i_val1, i_val2, i_val3, i_sel, i_auto, i_lz_blank, i_en,
        input  o_an, o_seg, o_dp, o_src, o_frame
    );

    modport slave (
        input  i_val0, i_val1, i_val2, i_val3, i_sel, i_auto, i_lz_blank, i_en,
        output o_an, o_seg, o_dp, o_src, o_frame
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit seven-segment scanner: snapshots one of four 32-bit sources per frame and
// multiplexes it onto active-low anode/cathode pins with an internal prescaler.
module sevenseg_scan_ctrl #(
    parameter int unsigned DIV        = 25000,
    parameter int unsigned ROT_FRAMES = 1000
) (
    input  logic               clk,
    input  logic               rstn,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned FCW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(ROT_FRAMES - 1);

    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [2:0]     dig_q,   dig_d;
    logic [FCW-1:0] fc_q,    fc_d;
    logic [31:0]    snap_q,  snap_d;
    logic [7:0]     an_q,    an_d;
    logic [6:0]     seg_q,   seg_d;
    logic           dp_q,    dp_d;
    logic [1:0]     src_q,   src_d;
    logic           frame_q, frame_d;

    logic           tick;
    logic [1:0]     src_nxt;
    logic [31:0]    val_sel;
    logic [31:0]    shifted;
    logic           lz_hit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign tick = (cnt_q == CNT_LAST) && bus.i_en;

    always_comb begin
        case (src_nxt)
            2'd0:    val_sel = bus.i_val0;
            2'd1:    val_sel = bus.i_val1;
            2'd2:    val_sel = bus.i_val2;
            default: val_sel = bus.i_val3;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        fc_d    = fc_q;
        snap_d  = snap_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        src_d   = src_q;
        frame_d = 1'b0;
        src_nxt = bus.i_sel;
        shifted = '0;
        lz_hit  = 1'b0;

        if (bus.i_auto) begin
            src_nxt = (fc_q == FC_LAST) ? src_q + 2'd1 : src_q;
        end else begin
            fc_d = '0;
        end

        // Disable beats a coincident tick, so no snapshot is taken on that edge.
        if (!bus.i_en) begin
            cnt_d = '0;
            dig_d = 3'd7;
            an_d  = '1;
            seg_d = '1;
            dp_d  = 1'b1;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                dig_d = dig_q + 3'd1;
                if (dig_q == 3'd7) begin
                    src_d   = src_nxt;
                    snap_d  = val_sel;
                    frame_d = 1'b1;
                    if (bus.i_auto) begin
                        fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
                    end
                end
                // Digit is decoded from snap_d so a frame edge shows the fresh snapshot.
                shifted = snap_d >> {dig_d, 2'b00};
                lz_hit  = bus.i_lz_blank && (dig_d != 3'd0) && (shifted == '0);
                an_d    = ~(8'b1 << dig_d);
                seg_d   = lz_hit ? '1 : hex7(shifted[3:0]);
                dp_d    = (dig_d != {1'b0, src_d});
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            dig_q   <= 3'd7;
            fc_q    <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
            src_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            fc_q    <= fc_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            src_q   <= src_d;
            frame_q <= frame_d;
        end
    end

    assign bus.o_an    = an_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_dp    = dp_q;
    assign bus.o_src   = src_q;
    assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a cycle-count reference model predicts every
// display change; a monitor pops and compares whenever the DUT outputs change.
module tb_sevenseg_scan_ctrl;
    localparam int DIV = 4;
    localparam int ROT = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    sevenseg_scan_ctrl_if bus();

    sevenseg_scan_ctrl #(.DIV(DIV), .ROT_FRAMES(ROT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] src;
        logic       frame;
    } exp_t;
    exp_t sbq[$];

    logic [6:0] segtab [16];
    initial segtab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                       7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                       7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_val(input int s);
        case (s)
            0:       return bus.i_val0;
            1:       return bus.i_val1;
            2:       return bus.i_val2;
            default: return bus.i_val3;
        endcase
    endfunction

    // Reference model: looks at the inputs the next rising edge will see and predicts it.
    int         en_run = 0;
    int         m_fc   = 0;
    int         m_src  = 0;
    logic [31:0] m_snap = '0;
    bit         lit    = 0;

    always @(negedge clk) begin : model
        int k;
        bit zeros;
        exp_t e;
        if (!rstn) begin
            sbq.delete();
            en_run = 0; m_fc = 0; m_src = 0; m_snap = '0; lit = 0;
        end else begin
            if (!bus.i_auto) m_fc = 0;
            if (!bus.i_en) begin
                en_run = 0;
                if (lit) begin
                    e = '{cyc + 1, 8'hFF, 7'h7F, 1'b1, 2'(m_src), 1'b0};
                    sbq.push_back(e);
                end
                lit = 0;
            end else begin
                en_run++;
                if (en_run % DIV == 0) begin
                    k = (en_run / DIV - 1) % 8;
                    if (k == 0) begin
                        if (bus.i_auto) begin
                            if (m_fc == ROT - 1) begin
                                m_fc  = 0;
                                m_src = (m_src + 1) % 4;
                            end else begin
                                m_fc++;
                            end
                        end else begin
                            m_src = int'(bus.i_sel);
                        end
                        m_snap = get_val(m_src);
                    end
                    zeros = 1;
                    for (int j = k; j < 8; j++) if (m_snap[4*j +: 4] != 4'h0) zeros = 0;
                    e.cyc   = cyc + 1;
                    e.an    = 8'hFF & ~(8'h01 << k);
                    e.seg   = (bus.i_lz_blank && k != 0 && zeros) ? 7'h7F : segtab[m_snap[4*k +: 4]];
                    e.dp    = (k == m_src) ? 1'b0 : 1'b1;
                    e.src   = 2'(m_src);
                    e.frame = (k == 0);
                    sbq.push_back(e);
                    lit = 1;
                end
            end
        end
    end

    logic [7:0] p_an  = 8'hFF;
    logic [6:0] p_seg = 7'h7F;
    logic       p_dp  = 1'b1;
    logic [1:0] p_src = 2'd0;

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rstn) begin
            chk("anode_onehot", ($countones(~bus.o_an) <= 1) ? 1 : 0, 1);
            if (bus.o_an != p_an || bus.o_seg != p_seg || bus.o_dp != p_dp ||
                bus.o_src != p_src || bus.o_frame) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_change: an=%h seg=%b dp=%b src=%0d frame=%b, nothing expected (cycle %0d)",
                             bus.o_an, bus.o_seg, bus.o_dp, bus.o_src, bus.o_frame, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("o_an", bus.o_an, e.an);
                    chk("o_seg", bus.o_seg, e.seg);
                    chk("o_dp", bus.o_dp, e.dp);
                    chk("o_src", bus.o_src, e.src);
                    chk("o_frame", bus.o_frame, e.frame);
                end
            end
        end
        p_an  = bus.o_an;
        p_seg = bus.o_seg;
        p_dp  = bus.o_dp;
        p_src = bus.o_src;
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},    bus.o_an,    8'hFF);
        chk({tag, "_seg"},   bus.o_seg,   7'h7F);
        chk({tag, "_dp"},    bus.o_dp,    1'b1);
        chk({tag, "_src"},   bus.o_src,   2'd0);
        chk({tag, "_frame"}, bus.o_frame, 1'b0);
    endtask

    initial begin
        bus.i_val0 = 32'h89ABCDEF;
        bus.i_val1 = 32'h01234567;
        bus.i_val2 = 32'h00C0FFEE;
        bus.i_val3 = 32'hDEADBEEF;
        bus.i_sel = 2'd0; bus.i_auto = 1'b0; bus.i_lz_blank = 1'b0; bus.i_en = 1'b1;
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset");
        run(3);
        rstn = 1'b1;

        // First tick lands DIV edges after release: digit 0 of 89ABCDEF is 'F'.
        repeat (DIV) @(posedge clk);
        #1;
        chk("first_frame_pulse", bus.o_frame, 1'b1);
        chk("first_an", bus.o_an, 8'hFE);
        chk("first_seg", bus.o_seg, 7'b0111000);
        chk("first_dp", bus.o_dp, 1'b0);
        #1;

        run(10);
        bus.i_val0 = 32'h0;
        run(40);
        bus.i_val2 = $urandom;
        run(5);
        bus.i_sel = 2'd2;
        run(60);

        bus.i_lz_blank = 1'b1;
        bus.i_sel  = 2'd1;
        bus.i_val1 = 32'h000000A5;
        run(70);
        bus.i_val1 = 32'h0;
        run(70);

        bus.i_val0 = 32'h11111111; bus.i_val1 = 32'h00002222;
        bus.i_val2 = 32'h33330000; bus.i_val3 = 32'h4444ABCD;
        bus.i_auto = 1'b1;
        run(DIV * 8 * 10);
        run(13);
        bus.i_auto = 1'b0;
        bus.i_sel  = 2'd3;
        run(70);

        run(3);
        bus.i_en = 1'b0;
        run(7);
        bus.i_en = 1'b1;
        run(50);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0: bus.i_val0 = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> ($urandom_range(0, 7) * 4));
                    1: bus.i_val1 = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> ($urandom_range(0, 7) * 4));
                    2: bus.i_val2 = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> ($urandom_range(0, 7) * 4));
                    default: bus.i_val3 = $urandom >> ($urandom_range(0, 8) * 4);
                endcase
            end
            if ($urandom_range(0, 99) < 2) bus.i_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) < 1) bus.i_auto = ~bus.i_auto;
            if ($urandom_range(0, 199) < 1) bus.i_lz_blank = ~bus.i_lz_blank;
            if ($urandom_range(0, 99) < 1) bus.i_en = ~bus.i_en;
            run(1);
        end

        // Asynchronous reset while a non-zero source is being scanned.
        bus.i_en = 1'b1; bus.i_auto = 1'b0; bus.i_sel = 2'd3; bus.i_val3 = 32'h76543210;
        run(50);
        rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        run(2);
        rstn = 1'b1;
        run(40);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
